// File: rtl/shift_rows_seq.sv
// shift_rows_seq: sequential AES ShiftRows / InvShiftRows over a full
// Rijndael state of NB columns (NB = 4, 6 or 8). The engine rotates one row
// per clock in a working register, then publishes the finished state.
//
// Handshake: start is sampled only in IDLE or DONE; sampling it captures
// state_in and inv. busy is high while rows are being rotated. done is a
// single-cycle pulse that coincides with the update of state_out. start
// while busy is ignored. Holding start through DONE chains transforms
// back-to-back, one every 5 cycles.
module shift_rows_seq #(
  parameter int NB = 4,
  localparam int W = 32 * NB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [W-1:0] state_in,
  output logic [W-1:0] state_out,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $fatal(1, "shift_rows_seq: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t         state;
  logic [W-1:0] work;
  logic [W-1:0] next_work;
  logic [1:0]   row_cnt;
  logic         inv_q;

  // Rijndael row offsets: wide (NB=8) states skip offset 2.
  function automatic int row_off(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  assign state_dbg = state;

  // Working state with row row_cnt rotated; all other rows pass through.
  always_comb begin
    next_work = work;
    for (int r = 0; r < 4; r++) begin
      if (row_cnt == 2'(r)) begin
        for (int c = 0; c < NB; c++) begin
          if (inv_q)
            next_work[W-1-8*(4*c+r) -: 8] =
              work[W-1-8*(4*((c+NB-row_off(r))%NB)+r) -: 8];
          else
            next_work[W-1-8*(4*c+r) -: 8] =
              work[W-1-8*(4*((c+row_off(r))%NB)+r) -: 8];
        end
      end
    end
  end

  // Control FSM and datapath registers; reset wins over any transform.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      work      <= '0;
      row_cnt   <= 2'd0;
      inv_q     <= 1'b0;
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            work    <= state_in;
            inv_q   <= inv;
            row_cnt <= 2'd0;
            busy    <= 1'b1;
            state   <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          work    <= next_work;
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == 2'd3) begin
            state_out <= next_work;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
